fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the RV32I in-order pipeline. It generates the PC and drives a variable-latency instruction-memory request/grant/response interface. It holds one fetched word and delivers it to decode (opcode = inst[6:0]), together with its PC and a valid bit. It honours decode stalls and redirects from EX (taken beq), discarding any in-flight fetch made stale by a redirect.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/if_id_reg.sv | 61 ++++++
 rtl/fetch_stage.sv | 119 +++++++++++
 tb/tb_fetch_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Types and constants shared by the RV32I in-order pipeline stages.
package pipe_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_FULL
    } fetch_state_t;

    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a one-entry skid buffer that catches a
// response arriving while decode is stalled.
module if_id_reg
    import pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            load,
    input  logic            skid_write,
    input  logic            id_stall,
    input  logic [31:0]     rdata,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            free,
    output logic            valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] pc
);

    logic            skid_valid;
    logic [31:0]     skid_inst;
    logic [XLEN-1:0] skid_pc;

    // Free means a new word may land here this cycle: empty, or being consumed.
    assign free = !valid || !id_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid      <= 1'b0;
            inst       <= NOP_INST;
            pc         <= '0;
            skid_valid <= 1'b0;
            skid_inst  <= NOP_INST;
            skid_pc    <= '0;
        end else if (flush) begin
            valid      <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (load) begin
                valid <= 1'b1;
                inst  <= rdata;
                pc    <= fetch_pc;
            end else if (skid_valid && !id_stall) begin
                valid      <= 1'b1;
                inst       <= skid_inst;
                pc         <= skid_pc;
                skid_valid <= 1'b0;
            end else if (!id_stall) begin
                valid <= 1'b0;
            end
            if (skid_write) begin
                skid_valid <= 1'b1;
                skid_inst  <= rdata;
                skid_pc    <= fetch_pc;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC generation, single-outstanding imem request FSM,
// redirect handling with stale-response discard, and the IF/ID register.
module fetch_stage
    import pipe_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            id_stall,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_target,
    output logic            if_id_valid,
    output logic [31:0]     if_id_inst,
    output logic [6:0]      if_id_opcode,
    output logic [XLEN-1:0] if_id_pc
);

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic            discard;
    logic            ifid_free;
    logic            resp_live;
    logic            ifid_load;
    logic            skid_write;

    assign imem_req     = rst_n && (state == S_REQ);
    assign imem_addr    = pc & ALIGN_MASK;
    assign if_id_opcode = if_id_inst[6:0];

    assign resp_live  = (state == S_WAIT) && imem_rvalid && !discard && !ex_redirect;
    assign ifid_load  = resp_live && ifid_free;
    assign skid_write = resp_live && !ifid_free;

    // A redirect always wins; a request granted in the same cycle is marked stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_REQ;
            pc      <= RESET_PC & ALIGN_MASK;
            req_pc  <= '0;
            discard <= 1'b0;
        end else if (ex_redirect) begin
            pc <= ex_target & ALIGN_MASK;
            case (state)
                S_REQ: begin
                    if (imem_gnt) begin
                        discard <= 1'b1;
                        state   <= S_WAIT;
                    end else begin
                        state <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        discard <= 1'b0;
                        state   <= S_REQ;
                    end else begin
                        discard <= 1'b1;
                    end
                end
                default: state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_gnt) begin
                        req_pc <= pc;
                        pc     <= pc + PC_STEP;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (discard) begin
                            discard <= 1'b0;
                            state   <= S_REQ;
                        end else if (ifid_free) begin
                            state <= S_REQ;
                        end else begin
                            state <= S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (!id_stall) state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase
        end
    end

    if_id_reg #(
        .XLEN(XLEN)
    ) u_ifid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (ex_redirect),
        .load      (ifid_load),
        .skid_write(skid_write),
        .id_stall  (id_stall),
        .rdata     (imem_rdata),
        .fetch_pc  (req_pc),
        .free      (ifid_free),
        .valid     (if_id_valid),
        .inst      (if_id_inst),
        .pc        (if_id_pc)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic, checked
// against an in-order program-stream model and a reactive memory model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        if_id_valid;
    logic [31:0] if_id_inst;
    logic [6:0]  if_id_opcode;
    logic [31:0] if_id_pc;

    int          n_vec;
    int          n_fail;
    int          consumed;
    logic [31:0] exp_pc;

    logic        mem_busy;
    logic [31:0] mem_addr;
    int          mem_delay;
    int          mem_lat;
    bit          gnt_en;
    bit          rand_mode;
    bit          seen24;

    fetch_stage #(
        .XLEN    (32),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_stall    (id_stall),
        .ex_redirect (ex_redirect),
        .ex_target   (ex_target),
        .if_id_valid (if_id_valid),
        .if_id_inst  (if_id_inst),
        .if_id_opcode(if_id_opcode),
        .if_id_pc    (if_id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of address.
    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00A0_0113;
        return (a ^ 32'h5A5A_3C3C) * 32'h9E37_79B1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs and memory response, run the program-order model, step the edge.
    task automatic applyStimulus(input bit stall, input bit redir, input logic [31:0] tgt);
        logic        rv;
        logic        g;
        logic [31:0] req_addr;
        logic [31:0] w;
        rv = mem_busy && (mem_delay == 0);
        g  = imem_req && gnt_en && (!rand_mode || ($urandom_range(0, 99) < 70));
        imem_rvalid = rv;
        imem_rdata  = rv ? memword(mem_addr) : $urandom;
        imem_gnt    = g;
        id_stall    = stall;
        ex_redirect = redir;
        ex_target   = tgt;
        req_addr    = imem_addr;
        if (imem_req && imem_addr == 32'h24) seen24 = 1'b1;
        if (imem_req) checkOutput("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
        if (redir) begin
            exp_pc = tgt & ~32'h3;
        end else if (if_id_valid && !stall) begin
            w = memword(exp_pc);
            checkOutput("seq_pc", if_id_pc, exp_pc);
            checkOutput("seq_inst", if_id_inst, w);
            checkOutput("seq_opcode", {25'b0, if_id_opcode}, {25'b0, w[6:0]});
            exp_pc = exp_pc + 32'd4;
            consumed++;
        end
        @(posedge clk);
        #1;
        if (rv) mem_busy = 1'b0;
        else if (mem_busy) mem_delay--;
        if (g) begin
            mem_busy  = 1'b1;
            mem_addr  = req_addr;
            mem_delay = rand_mode ? int'($urandom_range(0, 3)) : mem_lat - 1;
        end
    endtask

    task automatic assertReset();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        id_stall    = 1'b0;
        ex_redirect = 1'b0;
        ex_target   = '0;
        #2 rst_n = 1'b0;
        #1;
        mem_busy = 1'b0;
        exp_pc   = RESET_PC;
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req"}, {31'b0, imem_req}, 32'h0);
        checkOutput({tag, "_valid"}, {31'b0, if_id_valid}, 32'h0);
        checkOutput({tag, "_inst"}, if_id_inst, NOP);
        checkOutput({tag, "_pc"}, if_id_pc, 32'h0);
    endtask

    initial begin
        int vcount;
        n_vec = 0; n_fail = 0; consumed = 0;
        mem_busy = 1'b0; mem_addr = '0; mem_delay = 0; mem_lat = 1;
        gnt_en = 1'b1; rand_mode = 1'b0; seen24 = 1'b0;
        rst_n = 1'b1; imem_rdata = '0;

        // Reset and zero-wait fetch of the first two words
        assertReset();
        checkResetValues("reset");
        releaseReset();
        checkOutput("t1_req0", {31'b0, imem_req}, 32'h1);
        checkOutput("t1_addr0", imem_addr, 32'h0);
        applyStimulus(0, 0, 0);
        checkOutput("t1_wait_req", {31'b0, imem_req}, 32'h0);
        applyStimulus(0, 0, 0);
        checkOutput("t1_valid0", {31'b0, if_id_valid}, 32'h1);
        checkOutput("t1_pc0", if_id_pc, 32'h0);
        checkOutput("t1_inst0", if_id_inst, 32'h0050_0093);
        checkOutput("t1_opc0", {25'b0, if_id_opcode}, 32'h13);
        checkOutput("t1_addr4", imem_addr, 32'h4);
        applyStimulus(0, 0, 0);
        checkOutput("t1_gap", {31'b0, if_id_valid}, 32'h0);
        applyStimulus(0, 0, 0);
        checkOutput("t1_pc4", if_id_pc, 32'h4);
        checkOutput("t1_inst4", if_id_inst, 32'h00A0_0113);

        // Five-cycle decode stall: response for pc 8 lands in the skid
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0);
        checkOutput("t2_req", {31'b0, imem_req}, 32'h0);
        checkOutput("t2_valid", {31'b0, if_id_valid}, 32'h1);
        checkOutput("t2_pc", if_id_pc, 32'h4);
        checkOutput("t2_skid_v", {31'b0, dut.u_ifid.skid_valid}, 32'h1);
        checkOutput("t2_skid_pc", dut.u_ifid.skid_pc, 32'h8);
        applyStimulus(0, 0, 0);
        checkOutput("t2_pc8", if_id_pc, 32'h8);
        checkOutput("t2_req12", {31'b0, imem_req}, 32'h1);
        checkOutput("t2_addr12", imem_addr, 32'hC);

        // Redirect while waiting on 0x10; its response arrives three cycles later
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        mem_lat = 4;
        applyStimulus(0, 0, 0);
        applyStimulus(0, 1, 32'h40);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 0);
            checkOutput("t3_req", {31'b0, imem_req}, 32'h0);
            checkOutput("t3_valid", {31'b0, if_id_valid}, 32'h0);
        end
        applyStimulus(0, 0, 0);
        checkOutput("t3_valid_end", {31'b0, if_id_valid}, 32'h0);
        checkOutput("t3_addr40", imem_addr, 32'h40);

        // Redirect coinciding with the grant for 0x20
        mem_lat = 1;
        gnt_en  = 1'b0;
        applyStimulus(0, 1, 32'h20);
        checkOutput("t4_addr20", imem_addr, 32'h20);
        gnt_en = 1'b1;
        applyStimulus(0, 1, 32'h103);
        checkOutput("t4_req", {31'b0, imem_req}, 32'h0);
        applyStimulus(0, 0, 0);
        checkOutput("t4_valid", {31'b0, if_id_valid}, 32'h0);
        checkOutput("t4_addr100", imem_addr, 32'h100);
        checkOutput("t4_no24", {31'b0, seen24}, 32'h0);

        // Redirect under stall with the skid full
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("t5_skid_full", {31'b0, dut.u_ifid.skid_valid}, 32'h1);
        applyStimulus(1, 1, 32'h200);
        checkOutput("t5_valid", {31'b0, if_id_valid}, 32'h0);
        checkOutput("t5_skid", {31'b0, dut.u_ifid.skid_valid}, 32'h0);
        checkOutput("t5_addr200", imem_addr, 32'h200);

        // Asynchronous reset while a fetch is outstanding
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        mem_lat = 3;
        applyStimulus(1, 0, 0);
        checkOutput("t6_pre_valid", {31'b0, if_id_valid}, 32'h1);
        assertReset();
        checkResetValues("t6_async");
        releaseReset();
        checkOutput("t6_addr", imem_addr, RESET_PC);

        // PC wrap from 0xFFFF_FFFC to 0, with zero-wait throughput check
        mem_lat = 1;
        gnt_en  = 1'b0;
        applyStimulus(0, 1, 32'hFFFF_FFFF);
        checkOutput("t7_addr_top", imem_addr, 32'hFFFF_FFFC);
        gnt_en = 1'b1;
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("t7_addr_wrap", imem_addr, 32'h0);
        checkOutput("t7_pc_top", if_id_pc, 32'hFFFF_FFFC);
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, 0);
            if (if_id_valid) vcount++;
        end
        checkOutput("t7_throughput", vcount, 32'd10);

        // Random traffic: stalls, redirects, grant gaps and variable latency
        rand_mode = 1'b1;
        consumed  = 0;
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5, $urandom);
        end
        checkOutput("rand_progress", {31'b0, consumed > 200}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
